// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_pkg;

  localparam int DEF_LOG2N = 6;
  localparam int DEF_WIDTH = 16;
  localparam int MAX_LOG2N = 10;

  // Complex sample layout at the default component width; modules with a
  // different WIDTH declare the same {re, im} layout locally.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] re;
    logic [DEF_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  // Reverse the low log2n bits of value; bits above log2n come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                  input int log2n);
    logic [MAX_LOG2N-1:0] r;
    logic [MAX_LOG2N-1:0] v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < log2n) begin
        r = {r[MAX_LOG2N-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one write port and one registered read port, each with a bank select.
// Latency: read data appears one clock after rd_en with its address.
// Backpressure: none; caller guarantees a bank is not written while it is being read.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int AW = DEF_LOG2N,
  parameter int DW = 2 * DEF_WIDTH
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(2<<AW)-1];

  // Write port: bank select forms the top address bit.
  always_ff @(posedge clock) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Registered read port.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Streaming reorder buffer: bit-reversed FFT frames in, natural-order bursts out (ping-pong banks).
// Latency: first output 2 edges after the edge capturing a frame's last sample; N contiguous outputs.
// Backpressure: none; input rate <= 1/clk guarantees no overflow. Option macro: FFT_REORDER_FRAME_MARK_EN.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_input_en,
  input  logic [WIDTH-1:0] data_input_real,
  input  logic [WIDTH-1:0] data_input_complex,
  input  logic             reorder_mode,
  output logic             data_output_en,
  output logic [WIDTH-1:0] data_output_real,
  output logic [WIDTH-1:0] data_output_complex,
  output logic             busy
`ifdef FFT_REORDER_FRAME_MARK_EN
  ,
  output logic             data_output_first,
  output logic             data_output_last
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } sample_t;

  localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

  // Write side state
  logic [LOG2N-1:0] wcnt;
  logic             wbank;
  logic             mode_q;
  logic             cur_mode;
  logic [LOG2N-1:0] waddr;
  logic             frame_done;
  logic [1:0]       full;
  sample_t          wr_sample;

  // Read side state
  rd_state_t        state, state_nxt;
  logic [LOG2N-1:0] raddr, raddr_nxt;
  logic             rbank, rbank_nxt;
  logic             rd_issue;
  logic [LOG2N-1:0] rd_addr;
  logic             rd_done;
  logic             rd_vld;
  sample_t          rd_sample;

  // Mode applies from the first sample of a frame; later samples use the latched copy.
  always_comb begin
    cur_mode   = (wcnt == '0) ? reorder_mode : mode_q;
    waddr      = cur_mode ? LOG2N'(bitrev(MAX_LOG2N'(wcnt), LOG2N)) : wcnt;
    frame_done = data_input_en && (wcnt == LAST);
    wr_sample  = '{re: data_input_real, im: data_input_complex};
  end

  // Write counter, bank toggle and per-frame mode latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt   <= '0;
      wbank  <= 1'b0;
      mode_q <= 1'b0;
    end else if (data_input_en) begin
      wcnt <= wcnt + 1'b1;
      if (wcnt == '0) mode_q <= reorder_mode;
      if (wcnt == LAST) wbank <= ~wbank;
    end
  end

  // Bank occupancy: set when a frame completes, cleared when its last address is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      if (rd_done) full[rbank] <= 1'b0;
      if (frame_done) full[wbank] <= 1'b1;
    end
  end

  // Read FSM state register; rbank always names the oldest frame since banks fill and drain in turn.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RD_IDLE;
      raddr <= '0;
      rbank <= 1'b0;
    end else begin
      state <= state_nxt;
      raddr <= raddr_nxt;
      rbank <= rbank_nxt;
    end
  end

  // Read FSM next state; IDLE and DRAIN issue address 0 immediately so a newly full bank loses no cycle.
  always_comb begin
    state_nxt = state;
    raddr_nxt = raddr;
    rbank_nxt = rbank;
    rd_issue  = 1'b0;
    rd_addr   = raddr;
    rd_done   = 1'b0;
    case (state)
      RD_IDLE, RD_DRAIN: begin
        state_nxt = RD_IDLE;
        if (full[rbank]) begin
          rd_issue  = 1'b1;
          rd_addr   = '0;
          raddr_nxt = LOG2N'(1);
          state_nxt = RD_READ;
        end
      end
      RD_READ: begin
        rd_issue  = 1'b1;
        rd_addr   = raddr;
        raddr_nxt = raddr + 1'b1;
        if (raddr == LAST) begin
          rd_done   = 1'b1;
          rbank_nxt = ~rbank;
          state_nxt = full[~rbank] ? RD_READ : RD_DRAIN;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  fft_pingpong_ram #(
    .AW (LOG2N),
    .DW (2 * WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (data_input_en),
    .wr_bank (wbank),
    .wr_addr (waddr),
    .wr_data (wr_sample),
    .rd_en   (rd_issue),
    .rd_bank (rbank),
    .rd_addr (rd_addr),
    .rd_data (rd_sample)
  );

  // Output register; data forced to zero whenever the valid is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_vld              <= 1'b0;
      data_output_en      <= 1'b0;
      data_output_real    <= '0;
      data_output_complex <= '0;
    end else begin
      rd_vld              <= rd_issue;
      data_output_en      <= rd_vld;
      data_output_real    <= rd_vld ? rd_sample.re : '0;
      data_output_complex <= rd_vld ? rd_sample.im : '0;
    end
  end

`ifdef FFT_REORDER_FRAME_MARK_EN
  logic rd_first;
  logic rd_last;

  // Frame marks travel alongside the read pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_first          <= 1'b0;
      rd_last           <= 1'b0;
      data_output_first <= 1'b0;
      data_output_last  <= 1'b0;
    end else begin
      rd_first          <= rd_issue && (rd_addr == '0);
      rd_last           <= rd_issue && (rd_addr == LAST);
      data_output_first <= rd_vld && rd_first;
      data_output_last  <= rd_vld && rd_last;
    end
  end
`endif

  assign busy = (|full) || (state != RD_IDLE) || (wcnt != '0);

endmodule
